// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, instruction layout and the fetch-state encoding.
// Used by the instruction fetch unit and any decode logic that consumes its output.
package cpu_pkg;

    localparam int ADDR_W  = 14;
    localparam int INSTR_W = 16;

    // Opcode occupies the top nibble of every instruction word.
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    typedef enum logic [1:0] {
        S_HI   = 2'd0,
        S_LO   = 2'd1,
        S_CAP  = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr_word);
        return instr_word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Byte-wide instruction fetch: reads two big-endian bytes per 16-bit instruction,
// presents it to control with a valid/ready handshake and honours redirects.
module instr_fetch #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_rd_en,
    input  logic [7:0]                  mem_rdata,
    input  logic                        redirect,
    input  logic [ADDR_W-1:0]           redirect_addr,
    output logic [cpu_pkg::INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]           instr_pc,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [15:0]                 fetch_count
);
    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] RESET_PC_EVEN = {RESET_PC[ADDR_W-1:1], 1'b0};
    localparam logic [ADDR_W-1:0] PC_STEP       = {{(ADDR_W-2){1'b0}}, 2'b10};

    fetch_state_t         r_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [7:0]           r_hi_byte;
    logic [INSTR_W-1:0]   r_instr;
    logic [ADDR_W-1:0]    r_instr_pc;
    logic                 r_valid;
    logic [15:0]          r_count;

    logic                 w_handshake;
    logic [ADDR_W-1:0]    w_redirect_pc;
    logic [ADDR_W-1:0]    w_mem_addr;

    // Valid is only ever high in S_HOLD, so this also qualifies the state.
    assign w_handshake   = r_valid & instr_ready;
    assign w_redirect_pc = {redirect_addr[ADDR_W-1:1], 1'b0};

    always_comb begin
        w_mem_addr = r_pc;
        if (r_state == S_LO) begin
            w_mem_addr = {r_pc[ADDR_W-1:1], 1'b1};
        end
    end

    assign mem_addr  = w_mem_addr;
    assign mem_rd_en = reset_n & ((r_state == S_HI) | (r_state == S_LO));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_HI;
            r_pc       <= RESET_PC_EVEN;
            r_hi_byte  <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_count    <= '0;
        end else begin
            // A handshake counts even when a redirect lands in the same cycle.
            if (w_handshake) begin
                r_count <= r_count + 16'd1;
            end

            if (redirect) begin
                r_pc    <= w_redirect_pc;
                r_valid <= 1'b0;
                r_state <= S_HI;
            end else begin
                case (r_state)
                    S_HI: begin
                        r_state <= S_LO;
                    end
                    S_LO: begin
                        r_hi_byte <= mem_rdata;
                        r_state   <= S_CAP;
                    end
                    S_CAP: begin
                        r_instr    <= {r_hi_byte, mem_rdata};
                        r_instr_pc <= r_pc;
                        r_valid    <= 1'b1;
                        r_state    <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (w_handshake) begin
                            r_valid <= 1'b0;
                            r_pc    <= r_pc + PC_STEP;
                            r_state <= S_HI;
                        end
                    end
                    default: begin
                        r_state <= S_HI;
                    end
                endcase
            end
        end
    end

    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: byte memory model with one-cycle read latency,
// checks latency, stalls, redirects, address wrap and mid-fetch reset.
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam int AW = 14;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [7:0]    mem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic [15:0]   instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [15:0]   fetch_count;

    logic [7:0]    mem [0:(1<<AW)-1];

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch #(.ADDR_W(AW), .RESET_PC(14'h0000)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rdata    (mem_rdata),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns the addressed byte on the cycle after the strobe.
    always @(posedge clk) begin
        mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int unstable;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'hEE;
        mem[14'h0000] = 8'h12; mem[14'h0001] = 8'h34;
        mem[14'h0002] = 8'hAB; mem[14'h0003] = 8'hCD;
        mem[14'h0004] = 8'h11; mem[14'h0005] = 8'h22;
        mem[14'h0104] = 8'h56; mem[14'h0105] = 8'h78;
        mem[14'h0200] = 8'hDE; mem[14'h0201] = 8'hF0;
        mem[14'h3FFE] = 8'h9A; mem[14'h3FFF] = 8'hBC;

        reset_n       = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        instr_ready   = 1'b1;
        mem_rdata     = 8'h00;

        // Reset state
        step(); step();
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'h0);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_instr_pc", 32'(instr_pc), 32'h0);
        chk("rst_count", 32'(fetch_count), 32'h0);

        // First fetch: 0x1234 from address 0, ready held high
        reset_n = 1'b1;
        #1;
        chk("hi_rd_en", 32'(mem_rd_en), 32'h1);
        chk("hi_addr", 32'(mem_addr), 32'h0000);
        step();
        chk("lo_rd_en", 32'(mem_rd_en), 32'h1);
        chk("lo_addr", 32'(mem_addr), 32'h0001);
        step();
        chk("cap_rd_en", 32'(mem_rd_en), 32'h0);
        chk("cap_valid", 32'(instr_valid), 32'h0);
        step();
        chk("f0_valid", 32'(instr_valid), 32'h1);
        chk("f0_instr", 32'(instr), 32'h1234);
        chk("f0_pc", 32'(instr_pc), 32'h0000);
        chk("f0_count_pre", 32'(fetch_count), 32'h0);
        step();
        chk("f0_valid_drop", 32'(instr_valid), 32'h0);
        chk("f0_count", 32'(fetch_count), 32'h1);
        chk("f1_addr", 32'(mem_addr), 32'h0002);
        instr_ready = 1'b0;

        // Stall for 10 cycles with the instruction at address 2 held
        step(); step(); step();
        chk("f1_valid", 32'(instr_valid), 32'h1);
        chk("f1_instr", 32'(instr), 32'hABCD);
        chk("f1_pc", 32'(instr_pc), 32'h0002);
        pulses = 0;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mem_rd_en) pulses++;
            if (instr !== 16'hABCD || instr_valid !== 1'b1 || instr_pc !== 14'h0002) unstable++;
        end
        chk("stall_rd_pulses", 32'(pulses), 32'h0);
        chk("stall_unstable", 32'(unstable), 32'h0);
        instr_ready = 1'b1;
        step();
        chk("f1_count", 32'(fetch_count), 32'h2);
        chk("f2_addr", 32'(mem_addr), 32'h0004);
        chk("f2_rd_en", 32'(mem_rd_en), 32'h1);
        instr_ready = 1'b0;

        // Redirect during S_LO discards the byte already read from address 4
        step();
        chk("f2_lo_addr", 32'(mem_addr), 32'h0005);
        redirect = 1'b1;
        redirect_addr = 14'h0105;
        step();
        redirect = 1'b0;
        chk("redir_addr", 32'(mem_addr), 32'h0104);
        chk("redir_rd_en", 32'(mem_rd_en), 32'h1);
        chk("redir_valid", 32'(instr_valid), 32'h0);
        step(); step(); step();
        chk("redir_instr", 32'(instr), 32'h5678);
        chk("redir_pc", 32'(instr_pc), 32'h0104);
        chk("redir_valid2", 32'(instr_valid), 32'h1);

        // Redirect coinciding with a handshake: counted, target wins
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_addr = 14'h3FFF;
        step();
        redirect = 1'b0;
        chk("rh_count", 32'(fetch_count), 32'h3);
        chk("rh_addr", 32'(mem_addr), 32'h3FFE);
        chk("rh_valid", 32'(instr_valid), 32'h0);
        step(); step(); step();
        chk("top_instr", 32'(instr), 32'h9ABC);
        chk("top_pc", 32'(instr_pc), 32'h3FFE);

        // Handshake at 0x3FFE wraps pc to 0
        step();
        chk("wrap_addr", 32'(mem_addr), 32'h0000);
        chk("wrap_count", 32'(fetch_count), 32'h4);
        instr_ready = 1'b0;

        // Reset pulse during S_CAP
        step(); step();
        chk("cap2_rd_en", 32'(mem_rd_en), 32'h0);
        reset_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(instr_valid), 32'h0);
        chk("mrst_instr", 32'(instr), 32'h0);
        chk("mrst_count", 32'(fetch_count), 32'h0);
        chk("mrst_rd_en", 32'(mem_rd_en), 32'h0);
        step();
        reset_n = 1'b1;
        #1;
        chk("mrst_addr", 32'(mem_addr), 32'h0000);
        chk("mrst_rd_en2", 32'(mem_rd_en), 32'h1);
        step(); step(); step();
        chk("mrst_f_instr", 32'(instr), 32'h1234);
        chk("mrst_f_valid", 32'(instr_valid), 32'h1);

        // Redirect held for three cycles keeps restarting at the target
        redirect = 1'b1;
        redirect_addr = 14'h0201;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_redir_addr", 32'(mem_addr), 32'h0200);
            chk("hold_redir_rd_en", 32'(mem_rd_en), 32'h1);
            chk("hold_redir_valid", 32'(instr_valid), 32'h0);
        end
        redirect = 1'b0;
        step();
        chk("hold_redir_lo", 32'(mem_addr), 32'h0201);
        step(); step();
        chk("hr_instr", 32'(instr), 32'hDEF0);
        chk("hr_pc", 32'(instr_pc), 32'h0200);
        chk("hr_count", 32'(fetch_count), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 14, SHALL set the byte-address width of main memory (16Ki bytes).
REQ-002 Parameter RESET_PC, default 0, SHALL set the fetch address loaded on reset; bit 0 SHALL be treated as 0.
REQ-003 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 mem_addr  output  ADDR_W  byte address presented to main memory.
REQ-007 mem_rd_en  output  1  read strobe; memory returns mem_rdata on the following cycle.
REQ-008 mem_rdata  input  8  byte read data, valid exactly one cycle after mem_rd_en.
REQ-009 redirect  input  1  jump/branch request from control.
REQ-010 redirect_addr  input  ADDR_W  jump target; bit 0 ignored.
REQ-011 instr  output  16  assembled instruction for the IR.
REQ-012 instr_pc  output  ADDR_W  byte address of the instruction on instr.
REQ-013 instr_valid  output  1  instr/instr_pc hold a fetched instruction.
REQ-014 instr_ready  input  1  control accepts instr this cycle.
REQ-015 fetch_count  output  16  number of instructions accepted since reset.

Function
REQ-016 Instructions SHALL be big-endian: high byte at even address pc, low byte at pc+1.
REQ-017 FSM states SHALL be S_HI, S_LO, S_CAP, S_HOLD.
REQ-018 S_HI: mem_rd_en=1, mem_addr=pc; next state S_LO.
REQ-019 S_LO: capture mem_rdata as high byte; mem_rd_en=1, mem_addr=pc+1; next state S_CAP.
REQ-020 S_CAP: mem_rd_en=0; register instr={high byte, mem_rdata}, instr_pc=pc, instr_valid=1; next state S_HOLD.
REQ-021 S_HOLD: mem_rd_en=0; instr, instr_pc, and instr_valid SHALL stay stable until instr_ready=1.
REQ-022 Handshake: on instr_valid&&instr_ready, the FSM SHALL deassert instr_valid next cycle, set pc<=pc+2, increment fetch_count, and enter S_HI.
REQ-023 Latency SHALL be 3 cycles from entering S_HI to instr_valid=1; the peak rate SHALL be one instruction per 4 cycles.
REQ-024 pc+2 SHALL wrap modulo 2^ADDR_W (0x3FFE -> 0x0000); pc+1 never wraps because pc is even.
REQ-025 fetch_count SHALL wrap 0xFFFF -> 0x0000 with no flag.
REQ-026 Redirect in any state SHALL take priority: pc<={redirect_addr[ADDR_W-1:1],1'b0}, instr_valid<=0, state<=S_HI, and any in-flight byte is discarded.
REQ-027 When redirect coincides with a handshake in S_HOLD, the handshake SHALL count (fetch_count increments) and the next fetch SHALL come from the redirect target, not pc+2.
REQ-028 Redirect held high for several cycles SHALL restart the fetch each cycle with no memory read beyond the S_HI strobe.
REQ-029 instr_ready while instr_valid=0 SHALL be ignored.
REQ-030 mem_rd_en and mem_addr SHALL decode combinationally from state and pc; every other output SHALL be registered.

Reset
REQ-031 While reset_n=0, the block SHALL hold: state=S_HI, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fetch_count=0, and mem_rd_en forced to 0.
REQ-032 On the first rising clk edge after reset_n rises, the block SHALL be in S_HI with mem_rd_en=1 and mem_addr=RESET_PC.
REQ-033 Reset asserted mid-fetch SHALL abort the fetch immediately, with no partial instruction surviving.

Structure
REQ-034 Shared package cpu_pkg SHALL hold ADDR_W, INSTR_W=16, the fetch-state enumeration, and the opcode field position [15:12].
REQ-035 The FSM, pc, and assembly registers SHALL be implemented inline, with no sub-module.

Verification
REQ-036 Scenario: memory[0]=0x12, memory[1]=0x34, ready held 1 -> instr=0x1234, instr_pc=0, valid on the 3rd cycle after reset release, fetch_count=1 afterwards.
REQ-037 Scenario: ready held 0 for 10 cycles -> instr stable with no mem_rd_en pulses; ready=1 -> next fetch at address 2.
REQ-038 Scenario: redirect to 0x0105 during S_LO -> mem_addr=0x0104 next cycle, and the old high byte never appears on instr.
REQ-039 Scenario: pc=0x3FFE with handshake -> next mem_addr=0x0000.
REQ-040 Scenario: redirect and handshake in the same cycle -> fetch_count increments and the next fetch uses the redirect target.
REQ-041 Scenario: reset_n pulsed low during S_CAP -> instr_valid=0 and pc=RESET_PC, and the fetch restarts cleanly.
